// File: rtl/md_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: md_op codes,
// default latencies and the FSM state type.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_long_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_unit_divider.sv
// 32-bit signed/unsigned quotient/remainder core. Signed results are formed
// from magnitudes so the quotient truncates toward zero and the remainder
// follows the dividend's sign.
module md_divider
    import md_unit_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    logic        neg_n;
    logic        neg_d;
    logic [31:0] mag_n;
    logic [31:0] mag_d;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    assign neg_n    = is_signed & dividend[31];
    assign neg_d    = is_signed & divisor[31];
    assign div_zero = (divisor == 32'd0);

    // 0x80000000 is its own magnitude, so MIN / -1 falls out as 0x80000000 rem 0.
    assign mag_n = neg_n ? (32'd0 - dividend) : dividend;
    assign mag_d = neg_d ? (32'd0 - divisor)  : divisor;

    always_comb begin
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (!div_zero) begin
            q_mag = mag_n / mag_d;
            r_mag = mag_n % mag_d;
        end
    end

    assign quotient  = (neg_n ^ neg_d) ? (32'd0 - q_mag) : q_mag;
    assign remainder = neg_n ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO. Long ops (mult..divu) run a
// fixed-latency counter; mthi/mtlo write in one cycle without raising busy.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        start_o,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Handshake: a request is taken when start=1, flush=0 and busy=0 in the
    // same cycle (go). The stall unit must hold HI/LO ops while busy=1;
    // start during busy is dropped. start_o pulses the cycle after a long op
    // is taken, and HI/LO are final in the first cycle busy reads 0 again.
    md_state_e   state;
    md_op_e      op_in;
    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic        go;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    assign op_in = md_op_e'(md_op);
    assign go    = start & ~flush & ~busy;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
    // correct for both signed and unsigned interpretations.
    assign ext_a   = (op_q == MD_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b   = (op_q == MD_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign product = ext_a * ext_b;

    md_divider u_divider (
        .dividend  (a_q),
        .divisor   (b_q),
        .is_signed (op_q == MD_DIV),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= MD_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cnt     <= '0;
            busy    <= 1'b0;
            start_o <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        if (is_long_op(op_in)) begin
                            op_q    <= op_in;
                            a_q     <= a;
                            b_q     <= b;
                            cnt     <= is_mult_op(op_in) ? CNT_W'(MULT_CYCLES)
                                                         : CNT_W'(DIV_CYCLES);
                            busy    <= 1'b1;
                            start_o <= 1'b1;
                            state   <= ST_RUN;
                        end else if (op_in == MD_MTHI) begin
                            hi <= a;
                        end else if (op_in == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                        if (is_mult_op(op_q)) begin
                            hi <= product[63:32];
                            lo <= product[31:0];
                        end else if (!div_zero) begin
                            hi <= remainder;
                            lo <= quotient;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && busy));

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus random ops, checked by a queue
// scoreboard against a plain-arithmetic HI/LO model.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        start_o;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_op   (md_op),
        .flush   (flush),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .start_o (start_o),
        .hi      (hi),
        .lo      (lo)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    int          len_q[$];
    int          short_pend = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: results from the architectural definition of each op.
    task automatic model(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        int unsigned     ua;
        int unsigned     ub;
        sa = va;
        sb = vb;
        ua = va;
        ub = vb;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(va)) * longint'($signed(vb));
                {ref_hi, ref_lo} = sp;
                exp_q.push_back({ref_hi, ref_lo});
                len_q.push_back(MULT_N);
            end
            OP_MULTU: begin
                up = longint'(ua) * longint'(ub);
                {ref_hi, ref_lo} = up;
                exp_q.push_back({ref_hi, ref_lo});
                len_q.push_back(MULT_N);
            end
            OP_DIV: begin
                if (sb == 0) begin
                end else if (sa == 32'sh80000000 && sb == -1) begin
                    ref_lo = 32'h80000000;
                    ref_hi = 32'd0;
                end else begin
                    ref_lo = sa / sb;
                    ref_hi = sa % sb;
                end
                exp_q.push_back({ref_hi, ref_lo});
                len_q.push_back(DIV_N);
            end
            OP_DIVU: begin
                if (ub != 0) begin
                    ref_lo = ua / ub;
                    ref_hi = ua % ub;
                end
                exp_q.push_back({ref_hi, ref_lo});
                len_q.push_back(DIV_N);
            end
            OP_MTHI: begin
                ref_hi = va;
                exp_q.push_back({ref_hi, ref_lo});
                len_q.push_back(0);
                short_pend++;
            end
            OP_MTLO: begin
                ref_lo = va;
                exp_q.push_back({ref_hi, ref_lo});
                len_q.push_back(0);
                short_pend++;
            end
            default: begin
            end
        endcase
    endtask

    // driver tasks
    task automatic wait_idle(input bit rand_flush);
        int n;
        n = 0;
        while (busy && n < 100) begin
            flush = rand_flush ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            n++;
        end
        flush = 1'b0;
        chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic fl);
        wait_idle(1'b0);
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        flush = fl;
        tick();
        start = 1'b0;
        flush = 1'b0;
        md_op = OP_NONE;
        a     = $urandom;
        b     = $urandom;
        if (!fl) model(op, va, vb);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // scoreboard monitor
    task automatic retire(input string name, input int run_len, input logic chk_len);
        logic [63:0] e;
        int          l;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: retire with empty queue, got %h at %0t", name, {hi, lo}, $time);
        end else begin
            e = exp_q.pop_front();
            l = len_q.pop_front();
            chk(name, {hi, lo}, e);
            if (chk_len) chk("busy_len", 64'(run_len), 64'(l));
        end
    endtask

    initial begin
        bit in_run;
        int run_len;
        in_run  = 1'b0;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_run  = 1'b0;
                run_len = 0;
            end else begin
                if (start_o) begin
                    chk("start_o_pulse", {63'd0, in_run}, 64'd0);
                    in_run  = 1'b1;
                    run_len = 0;
                end
                if (in_run) begin
                    if (busy) begin
                        run_len++;
                    end else begin
                        in_run = 1'b0;
                        retire("long_result", run_len, 1'b1);
                    end
                end else begin
                    chk("busy_idle", {63'd0, busy}, 64'd0);
                end
                while (short_pend > 0) begin
                    short_pend--;
                    retire("short_result", 0, 1'b0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        md_op = OP_NONE;
        flush = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_start_o", {63'd0, start_o}, 64'd0);
        tick();

        issue(OP_MULT,  32'hFFFFFFFE, 32'd3, 1'b0);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0);
        issue(OP_DIVU,  32'd7, 32'd0, 1'b0);
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(1'b0);
        issue(OP_MTHI,  32'h12345678, 32'd0, 1'b0);
        issue(OP_MTLO,  32'h9ABCDEF0, 32'd0, 1'b0);
        tick();

        // start with flush: must not be taken
        issue(OP_MULT, 32'd1234, 32'd5678, 1'b1);
        @(negedge clk);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_start_o", {63'd0, start_o}, 64'd0);
        chk("flush_hilo", {hi, lo}, {ref_hi, ref_lo});
        tick();

        // flush while running does not cancel
        issue(OP_MULTU, 32'd100000, 32'd300000, 1'b0);
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        wait_idle(1'b0);

        // reset during the third cycle of a div
        issue(OP_DIV, 32'd1000, 32'd7, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        len_q.delete();
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        @(negedge clk);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        tick();

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 1) == 0) ? OP_NONE : OP_RSVD;
            else if (op == OP_NONE || op == OP_RSVD) op = OP_DIV;
            wait_idle(1'b1);
            issue(op, rnd32(), rnd32(), ($urandom_range(0, 7) == 0));
        end

        begin
            int n;
            n = 0;
            while ((exp_q.size() > 0 || busy) && n < 200) begin
                tick();
                n++;
            end
        end
        tick();
        @(negedge clk);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("final_hilo", {hi, lo}, {ref_hi, ref_lo});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
